// File: rtl/ff_exc_pkg.sv
// Shared excitation / next-state equations for the SR, JK and T flip-flop
// models, plus the common error-counter width and saturation value.
package ff_exc_pkg;

  localparam int unsigned CNT_W_DEF = 8;
  localparam logic [CNT_W_DEF-1:0] ERR_CNT_SAT = '1;

  typedef struct packed {
    logic s;
    logic r;
  } sr_exc_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_exc_t;

  // SR excitation: don't-cares resolved to 0, so S&R can never both be 1.
  function automatic sr_exc_t sr_exc(input logic q, input logic d);
    sr_exc_t e;
    e.s = d & ~q;
    e.r = ~d & q;
    return e;
  endfunction

  // JK excitation: don't-cares resolved to 0.
  function automatic jk_exc_t jk_exc(input logic q, input logic d);
    jk_exc_t e;
    e.j = d & ~q;
    e.k = ~d & q;
    return e;
  endfunction

  function automatic logic t_exc(input logic q, input logic d);
    return q ^ d;
  endfunction

  function automatic logic sr_next(input logic q, input logic s, input logic r);
    return s | (q & ~r);
  endfunction

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

  function automatic logic t_next(input logic q, input logic t);
    return q ^ t;
  endfunction

endpackage

// File: rtl/ff_model_bank.sv
// SR / JK / T model registers driven by the generated excitations, the
// comparator against the requested word, sticky flags and error counter.
module ff_model_bank
  import ff_exc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_load,
  input  logic [WIDTH-1:0] init_val,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d_dly,
  output logic             chk_valid,
  output logic             chk_err,
  output logic             sr_illegal,
  output logic [CNT_W-1:0] err_cnt
);

  // Package value covers the default width; any other width saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_SAT =
    (CNT_W == CNT_W_DEF) ? CNT_W'(ERR_CNT_SAT) : '1;

  logic [WIDTH-1:0] sr_q, jk_q, t_q;
  logic [WIDTH-1:0] sr_n, jk_n, t_n;
  logic             mismatch;
  logic             chk_v;

  // Next model state from the registered excitations, and its comparison.
  // Comparing the next-state values against d_dly at the update edge gives
  // the same result as comparing the updated models one cycle later, without
  // a second copy of the requested word.
  always_comb begin
    sr_n = sr_q;
    jk_n = jk_q;
    t_n  = t_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sr_n[i] = sr_next(sr_q[i], s[i], r[i]);
      jk_n[i] = jk_next(jk_q[i], j[i], k[i]);
      t_n[i]  = t_next(t_q[i], t[i]);
    end
    mismatch = (sr_n != d_dly) || (jk_n != d_dly) || (t_n != d_dly);
  end

  // Model update, check pipeline, sticky flags and saturating error count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q       <= '0;
      jk_q       <= '0;
      t_q        <= '0;
      chk_v      <= 1'b0;
      chk_err    <= 1'b0;
      sr_illegal <= 1'b0;
      err_cnt    <= '0;
    end else if (init_load) begin
      sr_q  <= init_val;
      jk_q  <= init_val;
      t_q   <= init_val;
      chk_v <= 1'b0;
    end else begin
      chk_v <= exc_valid;
      if (exc_valid) begin
        sr_q <= sr_n;
        jk_q <= jk_n;
        t_q  <= t_n;
        if ((s & r) != '0) begin
          sr_illegal <= 1'b1;
        end
        if (mismatch) begin
          chk_err <= 1'b1;
          if (err_cnt != CNT_SAT) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign chk_valid = chk_v & ~rst;

endmodule

// File: rtl/ff_excitation_gen.sv
// Converts a stream of requested next-state words into registered SR, JK
// and T excitations, tracks the current state and checks the result in a
// bank of flip-flop models.
module ff_excitation_gen
  import ff_exc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INIT_LOAD,
  input  logic [WIDTH-1:0] INIT_VAL,
  input  logic             D_valid,
  input  logic [WIDTH-1:0] D_in,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] T,
  output logic             exc_valid,
  output logic [WIDTH-1:0] Q,
  output logic             chk_valid,
  output logic             chk_err,
  output logic             sr_illegal,
  output logic [CNT_W-1:0] err_cnt
);

  logic [WIDTH-1:0] s_c, r_c, j_c, k_c, t_c;
  logic [WIDTH-1:0] d_dly;
  logic             exc_v_q;
  logic             accept;
  sr_exc_t          sr_b;
  jk_exc_t          jk_b;

  assign accept = D_valid & ~INIT_LOAD;

  // Stage 0: per-bit excitations from tracked state and requested word.
  always_comb begin
    s_c  = '0;
    r_c  = '0;
    j_c  = '0;
    k_c  = '0;
    t_c  = '0;
    sr_b = '0;
    jk_b = '0;
    if (accept) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        sr_b   = sr_exc(Q[i], D_in[i]);
        jk_b   = jk_exc(Q[i], D_in[i]);
        s_c[i] = sr_b.s;
        r_c[i] = sr_b.r;
        j_c[i] = jk_b.j;
        k_c[i] = jk_b.k;
        t_c[i] = t_exc(Q[i], D_in[i]);
      end
    end
  end

  // Excitation registers and state tracker; RST beats INIT_LOAD beats D_valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      S       <= '0;
      R       <= '0;
      J       <= '0;
      K       <= '0;
      T       <= '0;
      Q       <= '0;
      d_dly   <= '0;
      exc_v_q <= 1'b0;
    end else if (INIT_LOAD) begin
      S       <= '0;
      R       <= '0;
      J       <= '0;
      K       <= '0;
      T       <= '0;
      Q       <= INIT_VAL;
      exc_v_q <= 1'b0;
    end else begin
      S       <= s_c;
      R       <= r_c;
      J       <= j_c;
      K       <= k_c;
      T       <= t_c;
      exc_v_q <= D_valid;
      if (D_valid) begin
        Q     <= D_in;
        d_dly <= D_in;
      end
    end
  end

  // A word accepted just before reset must not show a valid pulse while
  // reset is asserted, so the registered valid is masked by RST.
  assign exc_valid = exc_v_q & ~RST;

  ff_model_bank #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bank (
    .clk        (CLK),
    .rst        (RST),
    .init_load  (INIT_LOAD),
    .init_val   (INIT_VAL),
    .exc_valid  (exc_valid),
    .s          (S),
    .r          (R),
    .j          (J),
    .k          (K),
    .t          (T),
    .d_dly      (d_dly),
    .chk_valid  (chk_valid),
    .chk_err    (chk_err),
    .sr_illegal (sr_illegal),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_ff_excitation_gen.sv
// Scoreboard bench for ff_excitation_gen: expected excitations and check
// results are queued when a word is driven and compared when the DUT
// presents them, including their arrival cycle.
module tb_ff_excitation_gen;

  logic       CLK;
  logic       RST;
  logic       INIT_LOAD;
  logic [3:0] INIT_VAL;
  logic       D_valid;
  logic [3:0] D_in;
  logic [3:0] S, R, J, K, T, Q;
  logic       exc_valid, chk_valid, chk_err, sr_illegal;
  logic [7:0] err_cnt;

  typedef struct {
    int         due;
    logic [3:0] s, r, j, k, t, q;
  } exc_item_t;

  typedef struct {
    int         due;
    logic       err;
    logic [7:0] cnt;
  } chk_item_t;

  exc_item_t exc_q[$];
  chk_item_t chk_q[$];
  exc_item_t ei;
  chk_item_t ci;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  bit   mon_en   = 0;

  // Reference state (from the excitation definitions, not the DUT)
  logic [3:0] q_m, sr_m, jk_m, t_m;
  logic       err_m;
  logic [7:0] cnt_m;

  ff_excitation_gen #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .INIT_LOAD  (INIT_LOAD),
    .INIT_VAL   (INIT_VAL),
    .D_valid    (D_valid),
    .D_in       (D_in),
    .S          (S),
    .R          (R),
    .J          (J),
    .K          (K),
    .T          (T),
    .exc_valid  (exc_valid),
    .Q          (Q),
    .chk_valid  (chk_valid),
    .chk_err    (chk_err),
    .sr_illegal (sr_illegal),
    .err_cnt    (err_cnt)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_m = '0; sr_m = '0; jk_m = '0; t_m = '0; err_m = 1'b0; cnt_m = '0;
  endtask

  task automatic model_init(input logic [3:0] v);
    q_m = v; sr_m = v; jk_m = v; t_m = v;
  endtask

  // Drive one word for one clock and queue what it must produce.
  task automatic send(input logic [3:0] d, input bit keep_chk);
    exc_item_t e;
    chk_item_t c;
    e.due = cyc + 1;
    e.t   = q_m ^ d;
    e.s   = d & ~q_m;
    e.j   = d & ~q_m;
    e.r   = ~d & q_m;
    e.k   = ~d & q_m;
    e.q   = d;
    exc_q.push_back(e);
    if (keep_chk) begin
      sr_m = e.s | (sr_m & ~e.r);
      jk_m = (e.j & ~jk_m) | (~e.k & jk_m);
      t_m  = t_m ^ e.t;
      if (sr_m !== d || jk_m !== d || t_m !== d) begin
        err_m = 1'b1;
        if (cnt_m != 8'hFF) cnt_m = cnt_m + 8'd1;
      end
      c.due = cyc + 2;
      c.err = err_m;
      c.cnt = cnt_m;
      chk_q.push_back(c);
    end
    q_m     = d;
    D_valid = 1'b1;
    D_in    = d;
    @(negedge CLK);
    D_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Output monitor: sample shortly after the falling edge.
  always begin
    @(negedge CLK);
    #2;
    if (mon_en) begin
      check("sr_illegal", sr_illegal, 0);
      if (exc_valid) begin
        if (exc_q.size() == 0) begin
          check("exc_unexpected", exc_valid, 0);
        end else begin
          ei = exc_q.pop_front();
          check("exc_latency", cyc, ei.due);
          check("S", S, ei.s);
          check("R", R, ei.r);
          check("J", J, ei.j);
          check("K", K, ei.k);
          check("T", T, ei.t);
          check("Q", Q, ei.q);
        end
      end
      if (chk_valid) begin
        if (chk_q.size() == 0) begin
          check("chk_unexpected", chk_valid, 0);
        end else begin
          ci = chk_q.pop_front();
          check("chk_latency", cyc, ci.due);
          check("chk_err", chk_err, ci.err);
          check("err_cnt", err_cnt, ci.cnt);
        end
      end
    end
  end

  initial begin
    // 1: reset held with a valid word present
    RST = 1'b1; INIT_LOAD = 1'b0; INIT_VAL = '0; D_valid = 1'b1; D_in = 4'b1111;
    model_reset();
    idle(2);
    #2;
    check("rst_S", S, 0);
    check("rst_R", R, 0);
    check("rst_J", J, 0);
    check("rst_K", K, 0);
    check("rst_T", T, 0);
    check("rst_Q", Q, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_chk_valid", chk_valid, 0);
    check("rst_chk_err", chk_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    RST = 1'b0; D_valid = 1'b0;
    mon_en = 1;

    // 2: single word from zero
    @(negedge CLK);
    send(4'b1010, 1);
    idle(3);
    check("t2_Q", Q, 4'b1010);

    // 3: back-to-back words
    send(4'b1010, 1);
    send(4'b0101, 1);
    send(4'b0101, 1);
    idle(3);
    check("t3_err_cnt", err_cnt, 0);

    // 4: INIT_LOAD wins over a same-cycle word
    INIT_LOAD = 1'b1; INIT_VAL = 4'b1111; D_valid = 1'b1; D_in = 4'b0000;
    model_init(4'b1111);
    @(negedge CLK);
    INIT_LOAD = 1'b0; D_valid = 1'b0;
    #2;
    check("t4_Q_init", Q, 4'b1111);
    check("t4_no_exc", exc_valid, 0);
    @(negedge CLK);
    send(4'b0110, 1);
    idle(3);

    // 4b: INIT_LOAD flushes the check of a word still in flight
    send(4'b0011, 0);
    INIT_LOAD = 1'b1; INIT_VAL = 4'b1000;
    model_init(4'b1000);
    @(negedge CLK);
    INIT_LOAD = 1'b0;
    idle(3);
    check("t4b_Q_init", Q, 4'b1000);

    // 5: reset the cycle after a word is accepted
    D_valid = 1'b1; D_in = 4'b1001;
    @(negedge CLK);
    D_valid = 1'b0; RST = 1'b1;
    #2;
    check("t5_exc_masked", exc_valid, 0);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    #2;
    check("t5_S", S, 0);
    check("t5_T", T, 0);
    check("t5_Q", Q, 0);
    check("t5_exc_valid", exc_valid, 0);
    check("t5_chk_valid", chk_valid, 0);
    idle(2);
    check("t5_chk_valid_late", chk_valid, 0);

    // 6: random words with random gaps
    @(negedge CLK);
    for (int i = 0; i < 64; i++) begin
      send(4'($urandom_range(0, 15)), 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("t6_chk_err_clean", chk_err, 0);

    // 6b: corrupt one JK model bit, then request a word that leaves it alone
    force dut.u_bank.jk_q = q_m ^ 4'b0001;
    @(negedge CLK);
    release dut.u_bank.jk_q;
    jk_m = q_m ^ 4'b0001;
    send(q_m ^ 4'b0110, 1);
    idle(3);
    check("t6_chk_err_set", chk_err, 1);
    check("t6_err_cnt_one", err_cnt, 1);

    // resync models; sticky state must survive INIT_LOAD
    INIT_LOAD = 1'b1; INIT_VAL = 4'b0101;
    model_init(4'b0101);
    @(negedge CLK);
    INIT_LOAD = 1'b0;
    send(4'b1100, 1);
    send(4'b0011, 1);
    idle(3);
    check("t6_chk_err_kept", chk_err, 1);
    check("t6_err_cnt_kept", err_cnt, 1);
    check("t6_sr_illegal", sr_illegal, 0);

    check("exc_queue_drained", exc_q.size(), 0);
    check("chk_queue_drained", chk_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ff_excitation_gen.md
Name: ff_excitation_gen

Overview:
Inverse of the D-based SR/JK/T flip-flop construction. Takes a stream of desired next-state words (D view) and produces the per-bit SR, JK and T excitation inputs that drive the current state to that value. Three internal model registers (SR, JK, T) are then driven from the generated excitations and checked against the requested word. Used as a stimulus/characterisation block in the sequential-primitives area.

Parameters:
WIDTH, 4, number of independent flip-flop bits per word
CNT_W, 8, width of saturating mismatch counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
INIT_LOAD  in  1  load tracked state and all models from INIT_VAL
INIT_VAL  in  WIDTH  value for INIT_LOAD
D_valid  in  1  D_in carries a requested next state this cycle
D_in  in  WIDTH  requested next-state word
S  out  WIDTH  SR set excitation, registered
R  out  WIDTH  SR reset excitation, registered
J  out  WIDTH  JK J excitation, registered
K  out  WIDTH  JK K excitation, registered
T  out  WIDTH  T excitation, registered
exc_valid  out  1  S/R/J/K/T valid this cycle
Q  out  WIDTH  tracked current state
chk_valid  out  1  model comparison result valid this cycle
chk_err  out  1  sticky: any model mismatch since reset
sr_illegal  out  1  sticky: S&R both 1 on any bit since reset
err_cnt  out  CNT_W  saturating count of mismatching comparisons

Behaviour:
- Reset (RST=1, synchronous): all outputs and internal registers go to 0; in-flight pipeline contents are discarded. RST overrides INIT_LOAD and D_valid.
- Stage 0 (cycle n, D_valid=1, INIT_LOAD=0), per bit with q=Q, d=D_in:
  - T=q^d; J=d&~q; K=~d&q; S=d&~q; R=~d&q. Don't-cares are always resolved to 0.
  - At cycle n+1: S/R/J/K/T are registered and exc_valid=1; Q becomes D_in. A stage-1 copy of D_in (d_dly) is held alongside.
- D_valid=0: exc_valid=0 next cycle. S/R/J/K/T are forced to 0 when not valid. Q holds.
- Stage 1 (exc_valid=1 at cycle n+1), models update from the registered excitations:
  - sr_q <= S | (sr_q & ~R)
  - jk_q <= (J & ~jk_q) | (~K & jk_q)
  - t_q <= t_q ^ T
- Stage 2 (cycle n+2): chk_valid=1. A mismatch is any of sr_q, jk_q or t_q differing from d_dly.
  - On mismatch: chk_err is set (sticky) and err_cnt increments, saturating at 2^CNT_W-1.
- sr_illegal is set when exc_valid=1 and (S&R)!=0. It must never fire in correct RTL.
- Latency: D_in to excitation is 1 cycle; D_in to check result is 2 cycles. Throughput is one word per cycle; back-to-back D_valid is fully supported.
- INIT_LOAD=1 (without RST):
  - Q, sr_q, jk_q and t_q all load INIT_VAL.
  - D_valid in the same cycle is ignored.
  - The exc_valid and chk_valid pipeline is flushed (both 0 on the following cycles for any word not yet checked).
  - chk_err, sr_illegal and err_cnt are preserved.
- Reset mid-stream: any word accepted in the cycle before RST produces no exc_valid or chk_valid pulse.
- Q always reflects the last accepted D_in or INIT_VAL.

Decomposition:
- Package ff_exc_pkg holds:
  - functions sr_exc, jk_exc and t_exc (q, d → excitation bits);
  - functions sr_next, jk_next and t_next (next-state equations);
  - shared localparam for the err_cnt saturation value.
- One sub-module, ff_model_bank, contains the stage-1 model registers, the stage-2 comparator, the sticky flags and err_cnt.
- The top level contains stage 0, the Q tracker and INIT/RST priority.

Test Plan:
1. Hold RST=1 for 2 cycles with D_valid=1, D_in=1111 → all outputs 0, exc_valid=0, chk_valid=0, Q=0000.
2. From Q=0000, send D_in=1010 → next cycle S=J=T=1010, R=K=0000, exc_valid=1, Q=1010; cycle after chk_valid=1, chk_err=0.
3. Back-to-back D_in=1010, 0101, 0101 →
   - 2nd word: T=1111, J=S=0101, K=R=1010.
   - 3rd word: S/R/J/K/T all 0000.
   - Three consecutive chk_valid pulses, err_cnt=0.
4. INIT_LOAD=1, INIT_VAL=1111 together with D_valid=1, D_in=0000 → Q=1111, no exc_valid; then D_in=0110 → T=1001, K=R=1001, J=S=0000.
5. D_valid=1 at cycle n, RST=1 at cycle n+1 → exc_valid and chk_valid never assert for that word; all outputs 0.
6. 64 random words with random D_valid gaps, plus a forced flip of jk_q on one check → chk_err=1 and err_cnt=1 after the forced case; sr_illegal stays 0 throughout.
